cnn_layer_scheduler: RTL and testbench

//  Sequences the LeNet-style CNN datapath (conv/pool compute engine + DMA) layer by layer.

---
 rtl/cnn_layer_scheduler.sv | 171 +++++++++++++++++
 tb/tb_cnn_layer_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_scheduler.sv
// Layer-by-layer job sequencer for the LeNet-style conv/pool engine and DMA.
// Walks a fixed five-entry layer table, one DMA load + engine job per step.
module cnn_layer_scheduler #(
    parameter int N_LAYERS = 5,
    parameter int JOB_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dma_req,
    output logic [2:0]       dma_layer,
    output logic [6:0]       dma_out_map,
    output logic [3:0]       dma_in_map,
    input  logic             dma_done,
    output logic             eng_valid,
    input  logic             eng_ready,
    output logic             eng_conv,
    output logic             eng_accum,
    output logic             eng_last,
    output logic [5:0]       eng_size,
    input  logic             eng_done,
    output logic             busy,
    output logic             finish,
    output logic [JOB_W-1:0] job_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DMA,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [2:0] LAST_LAYER = 3'(N_LAYERS - 1);

    state_t           state_q, state_d;
    logic [2:0]       layer_q, layer_d;
    logic [6:0]       out_q, out_d;
    logic [3:0]       in_q, in_d;
    logic [JOB_W-1:0] job_cnt_q, job_cnt_d;
    logic             dma_req_q, eng_valid_q, busy_q, finish_q;

    logic       lay_conv;
    logic [5:0] lay_size;
    logic [3:0] lay_in_max;
    logic [6:0] lay_out_max;
    logic       last_in, last_out, desc_vld;

    // Fixed network: in_max/out_max are map counts minus one
    always_comb begin
        lay_conv    = 1'b1;
        lay_size    = 6'd5;
        lay_in_max  = 4'd15;
        lay_out_max = 7'd119;
        case (layer_q)
            3'd0: begin
                lay_conv = 1'b1; lay_size = 6'd32;
                lay_in_max = 4'd0; lay_out_max = 7'd5;
            end
            3'd1: begin
                lay_conv = 1'b0; lay_size = 6'd28;
                lay_in_max = 4'd0; lay_out_max = 7'd5;
            end
            3'd2: begin
                lay_conv = 1'b1; lay_size = 6'd14;
                lay_in_max = 4'd5; lay_out_max = 7'd15;
            end
            3'd3: begin
                lay_conv = 1'b0; lay_size = 6'd10;
                lay_in_max = 4'd0; lay_out_max = 7'd15;
            end
            default: begin
                lay_conv = 1'b1; lay_size = 6'd5;
                lay_in_max = 4'd15; lay_out_max = 7'd119;
            end
        endcase
    end

    assign last_in  = !lay_conv || (in_q == lay_in_max);
    assign last_out = (out_q == lay_out_max);

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        out_d     = out_q;
        in_d      = in_q;
        job_cnt_d = job_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DMA;
                    layer_d   = 3'd0;
                    out_d     = 7'd0;
                    in_d      = 4'd0;
                    job_cnt_d = '0;
                end
            end
            S_DMA: begin
                if (dma_done) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (eng_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    if (job_cnt_q != '1) job_cnt_d = job_cnt_q + JOB_W'(1);
                    state_d = S_DMA;
                    if (!last_in) begin
                        in_d = in_q + 4'd1;
                    end else if (!last_out) begin
                        in_d  = 4'd0;
                        out_d = out_q + 7'd1;
                    end else begin
                        in_d  = 4'd0;
                        out_d = 7'd0;
                        if (layer_q == LAST_LAYER) begin
                            layer_d = 3'd0;
                            state_d = S_FIN;
                        end else begin
                            layer_d = layer_q + 3'd1;
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            layer_q     <= 3'd0;
            out_q       <= 7'd0;
            in_q        <= 4'd0;
            job_cnt_q   <= '0;
            dma_req_q   <= 1'b0;
            eng_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            out_q       <= out_d;
            in_q        <= in_d;
            job_cnt_q   <= job_cnt_d;
            dma_req_q   <= (state_d == S_DMA);
            eng_valid_q <= (state_d == S_ISSUE);
            busy_q      <= (state_d == S_DMA) || (state_d == S_ISSUE)
                        || (state_d == S_WAIT);
            finish_q    <= (state_d == S_FIN);
        end
    end

    // Descriptor fields read as zero whenever no job is being presented
    assign desc_vld    = dma_req_q | eng_valid_q;
    assign dma_req     = dma_req_q;
    assign eng_valid   = eng_valid_q;
    assign busy        = busy_q;
    assign finish      = finish_q;
    assign job_count   = job_cnt_q;
    assign dma_layer   = desc_vld ? layer_q : 3'd0;
    assign dma_out_map = desc_vld ? out_q : 7'd0;
    assign dma_in_map  = desc_vld ? in_q : 4'd0;
    assign eng_conv    = desc_vld & lay_conv;
    assign eng_accum   = desc_vld & lay_conv & (in_q != 4'd0);
    assign eng_last    = desc_vld & last_in;
    assign eng_size    = desc_vld ? lay_size : 6'd0;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed bench for cnn_layer_scheduler: reset, first jobs, full pass,
// backpressure with spurious pulses, and mid-pass reset.
module tb_cnn_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dma_done = 1'b0;
    logic        eng_ready = 1'b0;
    logic        eng_done = 1'b0;
    logic        dma_req, eng_valid, eng_conv, eng_accum, eng_last;
    logic        busy, finish;
    logic [2:0]  dma_layer;
    logic [6:0]  dma_out_map;
    logic [3:0]  dma_in_map;
    logic [5:0]  eng_size;
    logic [15:0] job_count;

    cnn_layer_scheduler #(.N_LAYERS(5), .JOB_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dma_req(dma_req), .dma_layer(dma_layer),
        .dma_out_map(dma_out_map), .dma_in_map(dma_in_map),
        .dma_done(dma_done), .eng_valid(eng_valid),
        .eng_ready(eng_ready), .eng_conv(eng_conv),
        .eng_accum(eng_accum), .eng_last(eng_last),
        .eng_size(eng_size), .eng_done(eng_done),
        .busy(busy), .finish(finish), .job_count(job_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          hs_n = 0;
    int          fin_n = 0;
    bit          auto_en = 1'b0;
    int          max_dly = 0;
    int          dma_w = -1;
    int          rdy_w = -1;
    int          done_w = 0;
    bit          done_pend = 1'b0;
    bit          hs_pend = 1'b0;
    bit          stable;
    logic [31:0] pend_desc;
    logic [31:0] pk0;
    logic [31:0] jobs [0:2047];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(int l, int o, int i, int c,
                                       int a, int la, int s);
        return {9'd0, 3'(l), 7'(o), 4'(i), 1'(c), 1'(a), 1'(la), 6'(s)};
    endfunction

    function automatic logic [31:0] cur();
        return {9'd0, dma_layer, dma_out_map, dma_in_map,
                eng_conv, eng_accum, eng_last, eng_size};
    endfunction

    // One cycle: observe at the falling edge, then drive responders
    task automatic tick();
        @(negedge clk);
        dma_done = 1'b0;
        eng_done = 1'b0;
        if (finish) fin_n++;
        if (hs_pend) begin
            if (hs_n < 2048) jobs[hs_n] = pend_desc;
            hs_n++;
            hs_pend   = 1'b0;
            done_w    = int'($urandom_range(max_dly, 0));
            done_pend = 1'b1;
        end
        if (auto_en) begin
            if (dma_req) begin
                if (dma_w < 0) dma_w = int'($urandom_range(max_dly, 0));
                if (dma_w == 0) begin
                    dma_done = 1'b1;
                    dma_w = -1;
                end else begin
                    dma_w--;
                end
            end else begin
                dma_w = -1;
            end
            if (eng_valid && !eng_ready) begin
                if (rdy_w < 0) rdy_w = int'($urandom_range(max_dly, 0));
                if (rdy_w == 0) begin
                    eng_ready = 1'b1;
                    hs_pend   = 1'b1;
                    pend_desc = cur();
                    rdy_w = -1;
                end else begin
                    rdy_w--;
                end
            end else if (!eng_valid) begin
                eng_ready = 1'b0;
            end
            if (done_pend) begin
                if (done_w == 0) begin
                    eng_done  = 1'b1;
                    done_pend = 1'b0;
                end else begin
                    done_w--;
                end
            end
        end
    endtask

    initial begin
        // Reset held with start asserted
        rst = 1'b1;
        start = 1'b1;
        repeat (2) tick();
        chk("rst_dma_req", 32'(dma_req), 32'd0);
        chk("rst_eng_valid", 32'(eng_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_job_count", 32'(job_count), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();

        // First jobs with instant responders
        hs_n = 0;
        fin_n = 0;
        max_dly = 0;
        auto_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        for (int t = 0; t < 2000 && hs_n < 19; t++) tick();
        chk("t2_reach19", 32'(hs_n >= 19), 32'd1);
        chk("job0", jobs[0], pk(0, 0, 0, 1, 0, 1, 32));
        chk("job5", jobs[5], pk(0, 5, 0, 1, 0, 1, 32));
        chk("job6", jobs[6], pk(1, 0, 0, 0, 0, 1, 28));
        chk("job11", jobs[11], pk(1, 5, 0, 0, 0, 1, 28));
        for (int k = 0; k < 6; k++)
            chk($sformatf("job%0d", 12 + k), jobs[12 + k],
                pk(2, 0, k, 1, int'(k != 0), int'(k == 5), 14));
        chk("job18", jobs[18], pk(2, 1, 0, 1, 0, 0, 14));

        // Remainder of the pass with random handshake delays
        max_dly = 5;
        for (int t = 0; t < 60000 && fin_n == 0; t++) tick();
        chk("t4_finish_seen", 32'(fin_n), 32'd1);
        chk("t4_handshakes", 32'(hs_n), 32'd2044);
        chk("t4_job_count", 32'(job_count), 32'd2044);
        chk("t4_busy_at_fin", 32'(busy), 32'd0);
        chk("job108", jobs[108], pk(3, 0, 0, 0, 0, 1, 10));
        chk("job124", jobs[124], pk(4, 0, 0, 1, 0, 0, 5));
        chk("job2043", jobs[2043], pk(4, 119, 15, 1, 1, 1, 5));
        repeat (20) tick();
        chk("t4_one_finish", 32'(fin_n), 32'd1);
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_count_held", 32'(job_count), 32'd2044);

        // Backpressure and spurious pulses, driven by hand
        auto_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        pk0 = pk(0, 0, 0, 1, 0, 1, 32);
        chk("t5_dma_req", 32'(dma_req), 32'd1);
        chk("t5_count_clr", 32'(job_count), 32'd0);
        chk("t5_desc_dma", cur(), pk0);
        eng_ready = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_ready = 1'b0;
        chk("t5_spur_dma_req", 32'(dma_req), 32'd1);
        chk("t5_spur_valid", 32'(eng_valid), 32'd0);
        dma_done = 1'b1;
        tick();
        chk("t5_issue_valid", 32'(eng_valid), 32'd1);
        chk("t5_issue_req", 32'(dma_req), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dma_done = i[0];
            eng_done = ~i[0];
            tick();
            if (!eng_valid || cur() !== pk0) stable = 1'b0;
        end
        chk("t5_stable", 32'(stable), 32'd1);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        chk("t5_wait_valid", 32'(eng_valid), 32'd0);
        chk("t5_wait_busy", 32'(busy), 32'd1);
        dma_done = 1'b1;
        tick();
        chk("t5_wait_spur_req", 32'(dma_req), 32'd0);
        chk("t5_wait_count", 32'(job_count), 32'd0);
        eng_done = 1'b1;
        tick();
        chk("t5_done_count", 32'(job_count), 32'd1);
        chk("t5_next_req", 32'(dma_req), 32'd1);
        chk("t5_job1_desc", cur(), pk(0, 1, 0, 1, 0, 1, 32));

        // Reset in the middle of a pass
        hs_n = 1;
        dma_w = -1;
        rdy_w = -1;
        done_pend = 1'b0;
        hs_pend = 1'b0;
        max_dly = 0;
        auto_en = 1'b1;
        for (int t = 0; t < 5000 && job_count < 16'd100; t++) tick();
        chk("t6_reach100", 32'(job_count), 32'd100);
        auto_en = 1'b0;
        hs_pend = 1'b0;
        done_pend = 1'b0;
        eng_ready = 1'b0;
        dma_done = 1'b0;
        eng_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_dma_req", 32'(dma_req), 32'd0);
        chk("t6_eng_valid", 32'(eng_valid), 32'd0);
        chk("t6_count", 32'(job_count), 32'd0);
        repeat (5) tick();
        chk("t6_no_finish", 32'(fin_n), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_restart_req", 32'(dma_req), 32'd1);
        chk("t6_restart_desc", cur(), pk0);
        chk("t6_restart_busy", 32'(busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
